// File: rtl/lru_age_updater.sv
// lru_age_updater: per-set LRU age store; accessed channel becomes age 0, the oldest stays at 7.
// Parameters: SET_COUNT (sets held), SET_WIDTH (set index width).
// Ports: clk, rst (sync, active-high); upd_valid/upd_ready/upd_set/upd_chan update request;
//        upd_done one-cycle write pulse; busy (not idle); rd_set read select; lru_out0..7 registered ages.
// Optional: define LRU_UPD_BYPASS_EN to forward the row being written to lru_out* in the same cycle.
module lru_age_updater #(
    parameter int SET_COUNT = 16,
    parameter int SET_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [SET_WIDTH-1:0] upd_set,
    input  logic [2:0]           upd_chan,
    output logic                 upd_done,
    output logic                 busy,
    input  logic [SET_WIDTH-1:0] rd_set,
    output logic [2:0]           lru_out0,
    output logic [2:0]           lru_out1,
    output logic [2:0]           lru_out2,
    output logic [2:0]           lru_out3,
    output logic [2:0]           lru_out4,
    output logic [2:0]           lru_out5,
    output logic [2:0]           lru_out6,
    output logic [2:0]           lru_out7
);
    localparam int CHAN_COUNT = 8;
    localparam int LRU_WIDTH = 3;
    typedef logic [CHAN_COUNT-1:0][LRU_WIDTH-1:0] row_t;
    typedef enum logic [1:0] {INIT, IDLE, CALC, WRITE} state_t;
    state_t               state, state_nx;
    logic [SET_WIDTH-1:0] init_cnt, cap_set;
    logic [2:0]           cap_chan;
    logic [LRU_WIDTH-1:0] acc_age;
    logic                 set_ok, rd_ok;
    row_t                 age [SET_COUNT];
    row_t                 cur_row, calc_row, init_row, new_row, lru_q;

    // Sets beyond SET_COUNT are accepted but never read or written.
    assign set_ok = 32'(cap_set) < SET_COUNT;
    assign rd_ok = 32'(rd_set) < SET_COUNT;
    assign upd_ready = state == IDLE;
    assign upd_done = state == WRITE;
    assign busy = state != IDLE;
    assign {lru_out7, lru_out6, lru_out5, lru_out4, lru_out3, lru_out2, lru_out1, lru_out0} = lru_q;

    // Channels younger than the accessed one age by one, so each row stays a permutation of 0..7.
    always_comb begin
        cur_row = set_ok ? age[cap_set] : '0;
        acc_age = cur_row[cap_chan];
        for (int w = 0; w < CHAN_COUNT; w++) begin
            init_row[w] = LRU_WIDTH'(w);
            calc_row[w] = (3'(w) == cap_chan) ? '0 :
                          (cur_row[w] < acc_age) ? cur_row[w] + LRU_WIDTH'(1) : cur_row[w];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    state_nx = (init_cnt == SET_WIDTH'(SET_COUNT - 1)) ? IDLE : INIT;
            IDLE:    state_nx = upd_valid ? CALC : IDLE;
            CALC:    state_nx = WRITE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT) init_cnt <= init_cnt + SET_WIDTH'(1);
            if (state == IDLE && upd_valid) begin
                cap_set <= upd_set;
                cap_chan <= upd_chan;
            end
            if (state == CALC) new_row <= calc_row;
        end
    end

    // Array has no reset; INIT fills it. A reset in CALC/WRITE suppresses the pending write.
    always_ff @(posedge clk) begin
        if (!rst && state == INIT) age[init_cnt] <= init_row;
        else if (!rst && state == WRITE && set_ok) age[cap_set] <= new_row;
    end

    always_ff @(posedge clk) begin
        if (rst || state == INIT) lru_q <= '0;
`ifdef LRU_UPD_BYPASS_EN
        else if (state == WRITE && set_ok && rd_set == cap_set) lru_q <= new_row;
`endif
        else lru_q <= rd_ok ? age[rd_set] : '0;
    end
endmodule

// File: tb/tb_lru_age_updater.sv
// tb_lru_age_updater: directed self-checking bench for lru_age_updater with hand-computed ages.
module tb_lru_age_updater;
    logic       clk = 0;
    logic       rst = 1;
    logic       upd_valid = 0;
    logic       upd_ready, upd_done, busy;
    logic [3:0] upd_set = 0;
    logic [2:0] upd_chan = 0;
    logic [3:0] rd_set = 0;
    logic [2:0] lru_out0, lru_out1, lru_out2, lru_out3, lru_out4, lru_out5, lru_out6, lru_out7;
    logic [23:0] lru;
    int checks = 0;
    int errors = 0;
    int low_cycles;
    logic [8:0] done_seq;
    logic       saw_done;

    lru_age_updater dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_set(upd_set), .upd_chan(upd_chan), .upd_done(upd_done), .busy(busy),
        .rd_set(rd_set), .lru_out0(lru_out0), .lru_out1(lru_out1), .lru_out2(lru_out2),
        .lru_out3(lru_out3), .lru_out4(lru_out4), .lru_out5(lru_out5), .lru_out6(lru_out6),
        .lru_out7(lru_out7)
    );

    always #5 clk = ~clk;
    assign lru = {lru_out7, lru_out6, lru_out5, lru_out4, lru_out3, lru_out2, lru_out1, lru_out0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] row(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7[2:0], a6[2:0], a5[2:0], a4[2:0], a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
    endfunction

    // Issue one update from IDLE (called at a negedge) and follow it through CALC and WRITE.
    task automatic upd(input logic [3:0] s, input logic [2:0] c);
        upd_valid = 1; upd_set = s; upd_chan = c;
        @(negedge clk);
        upd_valid = 0;
        check("calc_done", upd_done, 0);
        check("calc_ready", upd_ready, 0);
        @(negedge clk);
        check("write_done", upd_done, 1);
        check("write_busy", busy, 1);
        @(negedge clk);
        check("idle_done", upd_done, 0);
        check("idle_ready", upd_ready, 1);
    endtask

    // Release reset at a negedge, then expect exactly 16 cycles with upd_ready low.
    task automatic run_init(input string tag);
        low_cycles = 0;
        saw_done = 0;
        rst = 0;
        for (int i = 0; i < 40 && !upd_ready; i++) begin
            low_cycles++;
            saw_done |= upd_done;
            if (i == 8) check({tag, "_lru_zero"}, lru, 0);
            @(negedge clk);
        end
        check({tag, "_low_cycles"}, low_cycles, 16);
        check({tag, "_ready"}, upd_ready, 1);
        check({tag, "_no_done"}, saw_done, 0);
    endtask

    initial begin
        rd_set = 3;
        repeat (2) @(negedge clk);
        check("rst_ready", upd_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_done", upd_done, 0);
        check("rst_lru", lru, 0);
        run_init("init");
        @(negedge clk);
        check("init_set3", lru, row(0, 1, 2, 3, 4, 5, 6, 7));

        upd(3, 7);
`ifdef LRU_UPD_BYPASS_EN
        check("bypass_out7", lru_out7, 0);
`else
        check("bypass_out7", lru_out7, 7);
`endif
        @(negedge clk);
        check("set3_ch7", lru, row(1, 2, 3, 4, 5, 6, 7, 0));

        upd(3, 3);
        @(negedge clk);
        check("set3_ch3", lru, row(2, 3, 4, 0, 5, 6, 7, 1));
        rd_set = 2;
        @(negedge clk);
        check("set2_untouched", lru, row(0, 1, 2, 3, 4, 5, 6, 7));

        upd_valid = 1; upd_set = 5; upd_chan = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            done_seq[i] = upd_done;
        end
        upd_valid = 0;
        check("back_to_back_done", done_seq, 9'b010010010);
        rd_set = 5;
        @(negedge clk);
        check("set5_age0", lru, row(0, 1, 2, 3, 4, 5, 6, 7));

        upd_valid = 1; upd_set = 4; upd_chan = 7;
        @(negedge clk);
        upd_valid = 0;
        rst = 1;
        @(negedge clk);
        check("midrst_done", upd_done, 0);
        check("midrst_busy", busy, 1);
        rd_set = 4;
        run_init("reinit");
        @(negedge clk);
        check("set4_after_rst", lru, row(0, 1, 2, 3, 4, 5, 6, 7));
        rd_set = 3;
        @(negedge clk);
        check("set3_reinit", lru, row(0, 1, 2, 3, 4, 5, 6, 7));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lru_age_updater.md
# lru_age_updater

Per-set LRU age store and updater for the 8-channel set-associative cache. Holds one 3-bit age per channel per set, presents a selected set's ages to the victim-selection logic, and rewrites them after every hit or fill so that the accessed channel becomes youngest (age 0) and the oldest channel always carries age 7. It is the write side of the LRU scheme; the victim selector only reads the ages it produces.

## Interface

Parameters:
- SET_COUNT, 16, number of sets held (1..2^SET_WIDTH)
- SET_WIDTH, 4, set index width
- CHAN_COUNT, 8, channels per set; fixed, not overridable
- LRU_WIDTH, 3, age width; fixed

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- upd_valid  in  1  update request
- upd_ready  out  1  updater can accept request
- upd_set  in  SET_WIDTH  set being touched
- upd_chan  in  3  channel hit or filled
- upd_done  out  1  one-cycle pulse, update being written
- busy  out  1  high during init or while an update is in flight
- rd_set  in  SET_WIDTH  set to present on lru_out*
- lru_out0..lru_out7  out  3 each  registered ages of rd_set, channel 0..7

## Operation

- State: array age[SET_COUNT][8]; capture regs cap_set, cap_chan; new_row[8].
- FSM states INIT, IDLE, CALC, WRITE.
- INIT: init counter walks sets 0..SET_COUNT-1, one per cycle, writing age[s][w] = w. After last set -> IDLE.
- IDLE: upd_ready=1. upd_valid && upd_ready at an edge captures upd_set/upd_chan -> CALC.
- CALC: a = age[cap_set][cap_chan]; for each w: w==cap_chan -> 0; age[w] < a -> age[w]+1; else unchanged. Result registered into new_row -> WRITE.
- WRITE: upd_done=1; new_row written into age[cap_set] at the closing edge -> IDLE.
- Rule preserves a permutation of 0..7 in each set; no saturation or wrap possible.
- Accessed channel already age 0: row rewritten unchanged, upd_done still pulses.
- cap_set >= SET_COUNT: request accepted, CALC/WRITE run, no array write; upd_done still pulses.
- Read port: every edge lru_outN <= age[rd_set][N]; rd_set >= SET_COUNT returns 0. Held at 0 while in INIT.
- busy = (state != IDLE).

## Timing

- Reset: state INIT, init counter 0, upd_ready 0, upd_done 0, busy 1, lru_out* 0. Array contents undefined until INIT completes.
- INIT lasts exactly SET_COUNT cycles after rst deasserts; upd_ready rises in cycle SET_COUNT+1.
- Update accepted at edge E0: CALC in cycle after E0, WRITE after E1, array updated at E2, upd_ready high after E2. Next accept no earlier than E3: max one update per 3 cycles.
- upd_ready is low during CALC/WRITE; upd_valid then is ignored and must be held by the requester.
- Read latency 1 cycle from rd_set to lru_out*.
- rst asserted in any state, including CALC/WRITE: in-flight update dropped, no write, no upd_done, INIT restarts from set 0.

## Configuration

- LRU_UPD_BYPASS_EN defined: in WRITE, if rd_set == cap_set, lru_out* load new_row at that edge, so readers see the updated ages in the same cycle the array is written.
- Not defined: lru_out* always load the array, returning the pre-update ages in that case; the new ages appear one cycle later.

## Test plan

- Reset, release: upd_ready low for 16 cycles, high in cycle 17; rd_set=3 -> lru_out0..7 = 0,1,2,3,4,5,6,7.
- After init, update set 3 chan 7 -> upd_done pulses 2 cycles after accept; rd_set=3 -> 1,2,3,4,5,6,7,0.
- Then update set 3 chan 3 (age 4) -> 2,3,4,0,5,6,7,1; set 2 still 0..7.
- Update set 5 chan 0 (age 0) -> ages unchanged, upd_done pulses; upd_valid held continuously -> accepts spaced exactly 3 cycles apart.
- rd_set=3 during WRITE of set 3 chan 7 update: with LRU_UPD_BYPASS_EN lru_out7=0 next cycle; without, lru_out7=7, then 0 a cycle later.
- rst pulsed in CALC of set 4 update: no upd_done, busy stays high, INIT reruns 16 cycles, set 4 reads 0..7.
